// File: rtl/obstacle_lane_if.sv
// Bus bundle between the game controller and the obstacle lane:
// frame/game control and VGA scan position in, pixel and slot status out.
interface obstacle_lane_if #(
  parameter int NUM_OBS = 3
);
  localparam int CNT_W = $clog2(NUM_OBS + 1);

  logic                 start;
  logic                 game_status;
  logic                 fresh;
  logic [3:0]           speed;
  logic [8:0]           row_addr;
  logic [9:0]           col_addr;
  logic                 px;
  logic [NUM_OBS-1:0]   active;
  logic [CNT_W-1:0]     obs_count;

  modport master (
    output start, game_status, fresh, speed, row_addr, col_addr,
    input  px, active, obs_count
  );

  modport slave (
    input  start, game_status, fresh, speed, row_addr, col_addr,
    output px, active, obs_count
  );
endinterface

// File: rtl/obstacle_lane.sv
// Multi-obstacle scroller and renderer. Each slot holds an active flag and
// the distance it has scrolled from the right screen edge. New obstacles
// are spawned after a pseudo-random number of frame ticks, and one
// registered pixel bit is produced for the current VGA scan position.
module obstacle_lane #(
  parameter int                      NUM_OBS   = 3,
  parameter int                      SPR_W     = 60,
  parameter int                      SPR_H     = 58,
  parameter int                      Y_TOP     = 344,
  parameter int                      SCREEN_W  = 640,
  parameter int                      MIN_GAP   = 40,
  parameter int                      GAP_MASK  = 63,
  parameter logic [15:0]             LFSR_SEED = 16'hACE1,
  parameter logic [SPR_W*SPR_H-1:0]  SPRITE    = '1
) (
  input  logic            clk,
  input  logic            RESET_N,
  obstacle_lane_if.slave  bus
);

  localparam int          CNT_W   = $clog2(NUM_OBS + 1);
  localparam int          IDX_W   = $clog2(SPR_W * SPR_H);
  localparam int          END_POS = SCREEN_W + SPR_W;
  localparam logic [31:0] Y_LO    = Y_TOP;
  localparam logic [31:0] Y_HI    = Y_TOP + SPR_H;
  localparam logic [31:0] X_LO    = SCREEN_W;
  localparam logic [31:0] X_HI    = END_POS;
  localparam logic [31:0] W32     = SPR_W;

  logic [NUM_OBS-1:0] active_q, active_d;
  logic [10:0]        pos_q [NUM_OBS];
  logic [10:0]        pos_d [NUM_OBS];
  logic [15:0]        gap_q, gap_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               px_q, px_d;

  logic               tick;
  logic               lfsrFb;
  logic               spawnFound;
  logic               rowIn;
  logic [31:0]        rowOff;
  logic [31:0]        colSum;
  logic [IDX_W-1:0]   sprIdx;
  logic [CNT_W-1:0]   countVal;

  // A frame tick only advances the lane while the game is running.
  assign tick   = bus.fresh & bus.game_status;
  assign lfsrFb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Lane state registers; reset clears every slot and restarts the spawn timer.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      active_q <= '0;
      pos_q    <= '{default: '0};
      gap_q    <= 16'(MIN_GAP);
      lfsr_q   <= LFSR_SEED;
      px_q     <= 1'b0;
    end else begin
      active_q <= active_d;
      pos_q    <= pos_d;
      gap_q    <= gap_d;
      lfsr_q   <= lfsr_d;
      px_q     <= px_d;
    end
  end

  // Next lane state: start clears, a tick scrolls/retires/spawns from pre-tick state, else hold.
  always_comb begin
    active_d   = active_q;
    pos_d      = pos_q;
    gap_d      = gap_q;
    lfsr_d     = lfsr_q;
    spawnFound = 1'b0;
    if (bus.start) begin
      active_d = '0;
      pos_d    = '{default: '0};
      gap_d    = 16'(MIN_GAP);
      lfsr_d   = LFSR_SEED;
    end else if (tick) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        if (active_q[i]) begin
          pos_d[i] = pos_q[i] + 11'(bus.speed);
          if (pos_d[i] >= 11'(END_POS)) begin
            active_d[i] = 1'b0;
          end
        end
      end
      if (gap_q == '0) begin
        for (int i = 0; i < NUM_OBS; i++) begin
          if (!active_q[i] && !spawnFound) begin
            spawnFound  = 1'b1;
            active_d[i] = 1'b1;
            pos_d[i]    = '0;
          end
        end
        if (spawnFound) begin
          gap_d = 16'(MIN_GAP) + {8'h00, lfsr_q[7:0] & 8'(GAP_MASK)};
        end
      end else begin
        gap_d = gap_q - 16'd1;
      end
      lfsr_d = {lfsr_q[14:0], lfsrFb};
    end
  end

  // Pixel lookup: col+pos lands inside [SCREEN_W, SCREEN_W+SPR_W) for a visible slot, so no wrap is possible.
  always_comb begin
    px_d   = 1'b0;
    rowOff = 32'(bus.row_addr) - Y_LO;
    rowIn  = (32'(bus.row_addr) >= Y_LO) && (32'(bus.row_addr) < Y_HI);
    colSum = '0;
    sprIdx = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      colSum = 32'(bus.col_addr) + 32'(pos_q[i]);
      if (active_q[i] && rowIn && (colSum >= X_LO) && (colSum < X_HI)) begin
        sprIdx = IDX_W'((colSum - X_LO) + (rowOff * W32));
        if (SPRITE[sprIdx]) begin
          px_d = 1'b1;
        end
      end
    end
  end

  // Number of occupied slots for the collision logic.
  always_comb begin
    countVal = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      countVal = countVal + CNT_W'(active_q[i]);
    end
  end

  assign bus.px        = px_q;
  assign bus.active    = active_q;
  assign bus.obs_count = countVal;

endmodule
